// File: rtl/rs232_tx_down_h.sv
// RS232/UART transmitter: start bit, LSB-first data, optional parity, 1..2 stop bits.
// Bit timing comes from a down-counter reloaded with the latched K, so each bit lasts K+1 cycles.
module rs232_tx_down_h #(
  parameter int unsigned SIZE       = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic [SIZE-1:0]      K,
  input  logic [DATA_BITS-1:0] DATA,
  input  logic                 START,
  output logic                 READY,
  output logic                 DONE,
  output logic                 TX
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  localparam logic [3:0] LastData = 4'(DATA_BITS - 1);
  localparam logic [3:0] LastStop = 4'(STOP_BITS - 1);

  state_e               state_q;
  logic [SIZE-1:0]      cnt_q;
  logic [SIZE-1:0]      k_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [3:0]           bit_q;
  logic                 par_q;
  logic                 bit_end;

  assign bit_end = (cnt_q == '0);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      k_q     <= '0;
      shift_q <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
      TX      <= 1'b1;
      READY   <= 1'b1;
      DONE    <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (state_q == StIdle) begin
        if (START) begin
          k_q     <= K;
          cnt_q   <= K;
          shift_q <= DATA;
          par_q   <= (^DATA) ^ 1'(PARITY_ODD);
          bit_q   <= '0;
          state_q <= StStart;
          TX      <= 1'b0;
          READY   <= 1'b0;
        end
      end else if (!bit_end) begin
        cnt_q <= cnt_q - 1'b1;
      end else begin
        // Current bit ends at this edge: reload the timer and move to the next bit.
        cnt_q <= k_q;
        unique case (state_q)
          StStart: begin
            state_q <= StData;
            bit_q   <= '0;
            TX      <= shift_q[0];
          end
          StData: begin
            if (bit_q == LastData) begin
              bit_q <= '0;
              if (PARITY_EN != 0) begin
                state_q <= StParity;
                TX      <= par_q;
              end else begin
                state_q <= StStop;
                TX      <= 1'b1;
              end
            end else begin
              bit_q   <= bit_q + 1'b1;
              shift_q <= shift_q >> 1;
              TX      <= shift_q[1];
            end
          end
          StParity: begin
            state_q <= StStop;
            bit_q   <= '0;
            TX      <= 1'b1;
          end
          StStop: begin
            if (bit_q == LastStop) begin
              state_q <= StIdle;
              cnt_q   <= '0;
              bit_q   <= '0;
              READY   <= 1'b1;
              DONE    <= 1'b1;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
            TX <= 1'b1;
          end
          default: begin
            state_q <= StIdle;
            TX      <= 1'b1;
            READY   <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
